// File: rtl/temp_display_sequencer.sv
// Periodic sensor-read scheduler with timeout/retry supervision, a 4-sample moving average,
// and a frame-synchronous C/F display feed for the LED matrix.
module temp_display_sequencer #(
    parameter int SAMPLE_PERIOD = 25_000_000,
    parameter int TIMEOUT       = 250_000,
    parameter int MAX_RETRY     = 3,
    parameter int HOLD_FRAMES   = 240
) (
    input  logic       clk,
    input  logic       rst,
    output logic       i2c_start,
    input  logic       i2c_done,
    input  logic       i2c_nack,
    input  logic [7:0] i2c_data,
    output logic [7:0] avg_c,
    input  logic [7:0] conv_f,
    input  logic       frame_done,
    output logic [7:0] disp_temp,
    output logic       disp_unit,
    output logic       disp_valid,
    output logic       sensor_fault
);
    localparam int PER_W  = $clog2(SAMPLE_PERIOD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int RTY_W  = $clog2(MAX_RETRY + 2);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_STORE,
        ST_FAIL
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PER_W-1:0]  r_period;
    logic [TMO_W-1:0]  r_tmo;
    logic [RTY_W-1:0]  r_retry;
    logic              r_fault;
    logic              r_have;
    logic [1:0]        r_wptr;
    logic [7:0]        r_rx;
    logic [7:0]        r_ring [4];
    logic [7:0]        w_ring_nxt [4];
    logic [9:0]        w_sum;
    logic [7:0]        r_avg;
    logic [HOLD_W-1:0] r_hold;
    logic              r_unit;
    logic              r_disp_valid;
    logic [7:0]        r_disp_temp;
    logic              w_expire;
    logic              w_disp_en;
    logic              w_hold_last;
    logic              w_unit_nxt;

    // The period counter free-runs in every state so the read cadence never drifts.
    assign w_expire = (r_period == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_expire) w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i2c_done && !i2c_nack)
                    w_state_nxt = ST_STORE;
                else if (i2c_done || r_tmo == TMO_LAST)
                    w_state_nxt = ST_FAIL;
            end
            ST_STORE: w_state_nxt = ST_IDLE;
            ST_FAIL:  w_state_nxt = (r_retry < RTY_MAX) ? ST_START : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= PER_LAST;
            r_tmo    <= '0;
            r_retry  <= '0;
            r_fault  <= 1'b0;
            r_have   <= 1'b0;
            r_wptr   <= 2'd0;
            r_avg    <= 8'd0;
        end else begin
            r_period <= w_expire ? PER_LAST : r_period - PER_W'(1);
            if (r_state == ST_START)
                r_tmo <= '0;
            else if (r_state == ST_WAIT)
                r_tmo <= r_tmo + TMO_W'(1);
            if (r_state == ST_STORE) begin
                r_retry <= '0;
                r_fault <= 1'b0;
                r_have  <= 1'b1;
                r_wptr  <= r_have ? r_wptr + 2'd1 : 2'd1;
                r_avg   <= w_sum[9:2];
            end else if (r_state == ST_FAIL) begin
                if (r_retry < RTY_MAX) begin
                    r_retry <= r_retry + RTY_W'(1);
                end else begin
                    r_fault <= 1'b1;
                    r_retry <= '0;
                    r_have  <= 1'b0;
                end
            end
        end
    end

    // Sample capture and ring storage are pure data; the r_have flag guards their use.
    always_ff @(posedge clk) begin
        if (r_state == ST_WAIT && i2c_done)
            r_rx <= i2c_data;
        if (r_state == ST_STORE)
            r_ring <= w_ring_nxt;
    end

    always_comb begin
        w_ring_nxt = r_ring;
        if (!r_have) begin
            for (int i = 0; i < 4; i++)
                w_ring_nxt[i] = r_rx;
        end else begin
            w_ring_nxt[r_wptr] = r_rx;
        end
        w_sum = 10'(w_ring_nxt[0]) + 10'(w_ring_nxt[1])
              + 10'(w_ring_nxt[2]) + 10'(w_ring_nxt[3]);
    end

    assign w_disp_en   = frame_done && (r_disp_valid || r_have);
    assign w_hold_last = (r_hold == HOLD_LAST);
    assign w_unit_nxt  = w_hold_last ? ~r_unit : r_unit;

    // Display state moves only on frame boundaries, using the average registered before this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold       <= '0;
            r_unit       <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_temp  <= 8'd0;
        end else if (w_disp_en) begin
            r_hold       <= w_hold_last ? '0 : r_hold + HOLD_W'(1);
            r_unit       <= w_unit_nxt;
            r_disp_valid <= 1'b1;
            r_disp_temp  <= w_unit_nxt ? conv_f : r_avg;
        end
    end

    assign i2c_start    = (r_state == ST_START);
    assign avg_c        = r_avg;
    assign disp_temp    = r_disp_temp;
    assign disp_unit    = r_unit;
    assign disp_valid   = r_disp_valid;
    assign sensor_fault = r_fault;

endmodule
